// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: bus width, default
// memory depth and the ownership FSM encoding.
package dmem_arbiter_pkg;

    localparam int WIDTH_C       = 32;
    localparam int DEPTH_WORDS_C = 64;

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request side driven by the
// requester, grant and registered response driven by the arbiter.
interface dmem_arbiter_if
    import dmem_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_C
);
    logic             req;
    logic             we;
    logic             lock;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic             gnt;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
    logic             err;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arb_resp.sv
// Per-port response register: captures read data (or zero for writes and
// out-of-range accesses) plus the range error on a grant, and pulses rvalid
// for exactly one cycle. Without a grant rdata/err keep their last value.
module dmem_arb_resp
    import dmem_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_C
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gnt,
    input  logic             we,
    input  logic             in_range,
    input  logic [WIDTH-1:0] mem_rd,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             err
);

    logic             rvalid_r;
    logic [WIDTH-1:0] rdata_r;
    logic             err_r;

    // Capture the response of the access granted this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_r <= 1'b0;
            rdata_r  <= {WIDTH{1'b0}};
            err_r    <= 1'b0;
        end else if (gnt) begin
            rvalid_r <= 1'b1;
            rdata_r  <= (in_range && !we) ? mem_rd : {WIDTH{1'b0}};
            err_r    <= ~in_range;
        end else begin
            rvalid_r <= 1'b0;
        end
    end

    assign rvalid = rvalid_r;
    assign rdata  = rdata_r;
    assign err    = err_r;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory. Port 0 is the
// core, port 1 the debug/program loader. Grants are combinational, a locked
// grant keeps ownership until the owner releases lock or drops req, and each
// access gets a one-cycle-later registered response.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int WIDTH       = WIDTH_C,
    parameter int DEPTH_WORDS = DEPTH_WORDS_C,
    parameter int RR_EN       = 1
) (
    input  logic             clk,
    input  logic             reset,
    dmem_arbiter_if.slave    m0,
    dmem_arbiter_if.slave    m1,
    output logic [WIDTH-1:0] mem_addr,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_wr_data,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam logic [WIDTH-1:0] DEPTH_L = WIDTH'(DEPTH_WORDS);

    arb_state_e state_r;
    arb_state_e state_nxt_s;
    logic       last_r;      // port granted most recently (1 = port 1)
    logic       last_nxt_s;
    logic       gnt0_s;
    logic       gnt1_s;
    logic       in_range0_s;
    logic       in_range1_s;

    // Word address decode; the two byte-offset bits never affect range.
    assign in_range0_s = ({2'b00, m0.addr[WIDTH-1:2]} < DEPTH_L);
    assign in_range1_s = ({2'b00, m1.addr[WIDTH-1:2]} < DEPTH_L);

    // Ownership state and round-robin pointer; last=1 lets port 0 win first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_ARB;
            last_r  <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            last_r  <= last_nxt_s;
        end
    end

    // Grant selection and ownership transitions.
    always_comb begin
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        case (state_r)
            ST_ARB: begin
                if (m0.req && m1.req) begin
                    if ((RR_EN != 0) && (last_r == 1'b0)) begin
                        gnt1_s = 1'b1;
                    end else begin
                        gnt0_s = 1'b1;
                    end
                end else if (m0.req) begin
                    gnt0_s = 1'b1;
                end else if (m1.req) begin
                    gnt1_s = 1'b1;
                end else begin
                    gnt0_s = 1'b0;
                end
                if (gnt0_s && m0.lock) begin
                    state_nxt_s = ST_OWN0;
                end else if (gnt1_s && m1.lock) begin
                    state_nxt_s = ST_OWN1;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_OWN0: begin
                // A dropped req releases ownership without a grant.
                if (m0.req) begin
                    gnt0_s      = 1'b1;
                    state_nxt_s = m0.lock ? ST_OWN0 : ST_ARB;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_OWN1: begin
                if (m1.req) begin
                    gnt1_s      = 1'b1;
                    state_nxt_s = m1.lock ? ST_OWN1 : ST_ARB;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            default: begin
                state_nxt_s = ST_ARB;
            end
        endcase
        if (gnt0_s) begin
            last_nxt_s = 1'b0;
        end else if (gnt1_s) begin
            last_nxt_s = 1'b1;
        end else begin
            last_nxt_s = last_r;
        end
    end

    // Memory-side mux; port 0 drives the bus when nobody is granted, and
    // out-of-range or reset-cycle writes never reach the memory.
    always_comb begin
        mem_addr    = m0.addr;
        mem_wr_data = m0.wdata;
        if (gnt1_s) begin
            mem_addr    = m1.addr;
            mem_wr_data = m1.wdata;
        end else begin
            mem_addr    = m0.addr;
            mem_wr_data = m0.wdata;
        end
        mem_we = ((gnt0_s & m0.we & in_range0_s) |
                  (gnt1_s & m1.we & in_range1_s)) & ~reset;
    end

    assign m0.gnt = gnt0_s;
    assign m1.gnt = gnt1_s;

    dmem_arb_resp #(.WIDTH(WIDTH)) u_resp0 (
        .clk      (clk),
        .reset    (reset),
        .gnt      (gnt0_s),
        .we       (m0.we),
        .in_range (in_range0_s),
        .mem_rd   (mem_rd),
        .rvalid   (m0.rvalid),
        .rdata    (m0.rdata),
        .err      (m0.err)
    );

    dmem_arb_resp #(.WIDTH(WIDTH)) u_resp1 (
        .clk      (clk),
        .reset    (reset),
        .gnt      (gnt1_s),
        .we       (m1.we),
        .in_range (in_range1_s),
        .mem_rd   (mem_rd),
        .rvalid   (m1.rvalid),
        .rdata    (m1.rdata),
        .err      (m1.err)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic from
// both requesters, checked by a reference model feeding per-port response
// queues that an independent monitor drains.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.WIDTH(32)) p0 ();
    dmem_arbiter_if #(.WIDTH(32)) p1 ();
    dmem_arbiter_if #(.WIDTH(32)) f0 ();
    dmem_arbiter_if #(.WIDTH(32)) f1 ();

    logic [31:0] mem_addr, mem_wr_data, mem_rd;
    logic        mem_we;
    logic [31:0] fx_addr, fx_wd;
    logic        fx_we;

    dmem_arbiter #(.WIDTH(32), .DEPTH_WORDS(DEPTH), .RR_EN(1)) dut (
        .clk(clk), .reset(reset), .m0(p0), .m1(p1),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wr_data(mem_wr_data), .mem_rd(mem_rd)
    );

    // Fixed-priority instance sharing the same request stimulus.
    dmem_arbiter #(.WIDTH(32), .DEPTH_WORDS(DEPTH), .RR_EN(0)) u_fix (
        .clk(clk), .reset(reset), .m0(f0), .m1(f1),
        .mem_addr(fx_addr), .mem_we(fx_we), .mem_wr_data(fx_wd), .mem_rd(32'h0)
    );

    assign f0.req = p0.req;  assign f0.we = p0.we;  assign f0.lock = p0.lock;
    assign f0.addr = p0.addr; assign f0.wdata = p0.wdata;
    assign f1.req = p1.req;  assign f1.we = p1.we;  assign f1.lock = p1.lock;
    assign f1.addr = p1.addr; assign f1.wdata = p1.wdata;

    // Memory behind the arbiter: write aliases on the low index bits so a
    // leaked out-of-range write corrupts a real word; reads out of range
    // return junk the arbiter must replace by zero.
    logic [31:0] dmem_arr [DEPTH];
    logic [31:0] ref_mem  [DEPTH];
    assign mem_rd = (mem_addr[31:8] == 24'h0) ? dmem_arr[mem_addr[7:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) if (mem_we) dmem_arr[mem_addr[7:2]] <= mem_wr_data;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] init_val(int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    resp_t rq0[$];
    resp_t rq1[$];
    int    owner  = -1;   // -1: free, else port holding the lock
    int    last_g = 1;    // port granted most recently
    int    cyc    = 0;
    bit    mon_en = 1'b0;
    logic [31:0] seen_rdata [2];
    logic        seen_err   [2];

    always @(posedge clk) cyc <= cyc + 1;

    // Who may be served this cycle, from the arbitration rules.
    function automatic int predict_grant(logic r0, logic r1);
        if (owner == 0) return r0 ? 0 : -1;
        if (owner == 1) return r1 ? 1 : -1;
        if (r0 && r1)   return (last_g == 0) ? 1 : 0;
        if (r0)         return 0;
        if (r1)         return 1;
        return -1;
    endfunction

    // Grant/bus check and expected-response generation, mid-cycle.
    always @(negedge clk) if (mon_en) begin
        int          g;
        logic [31:0] a, wd;
        logic        w, lk, inr;
        resp_t       e;
        lk = 1'b0;
        g  = predict_grant(p0.req, p1.req);
        chk("m0_gnt", 32'(p0.gnt), 32'(g == 0));
        chk("m1_gnt", 32'(p1.gnt), 32'(g == 1));
        a = (g == 1) ? p1.addr : p0.addr;
        chk("mem_addr", mem_addr, a);
        if (g >= 0) begin
            w   = (g == 1) ? p1.we    : p0.we;
            wd  = (g == 1) ? p1.wdata : p0.wdata;
            lk  = (g == 1) ? p1.lock  : p0.lock;
            inr = (a[31:2] < 30'd64);
            chk("mem_we", 32'(mem_we), 32'(w && inr && !reset));
            if (w && inr && !reset) chk("mem_wr_data", mem_wr_data, wd);
            if (!reset) begin
                e.rdata = (!w && inr) ? ref_mem[a[7:2]] : 32'h0;
                e.err   = !inr;
                e.cyc   = cyc;
                if (g == 0) rq0.push_back(e); else rq1.push_back(e);
                if (w && inr) ref_mem[a[7:2]] = wd;
            end
        end else begin
            chk("mem_we_idle", 32'(mem_we), 32'h0);
        end
        if (reset) begin
            owner  = -1;
            last_g = 1;
        end else begin
            if (owner >= 0) begin
                if (g < 0 || !lk) owner = -1;
            end else if (g >= 0 && lk) begin
                owner = g;
            end
            if (g >= 0) last_g = g;
        end
    end

    task automatic check_resp(input int p);
        logic        rv, er;
        logic [31:0] rd;
        resp_t       e;
        int          qs;
        rv = (p == 1) ? p1.rvalid : p0.rvalid;
        rd = (p == 1) ? p1.rdata  : p0.rdata;
        er = (p == 1) ? p1.err    : p0.err;
        qs = (p == 1) ? rq1.size() : rq0.size();
        if (reset) begin
            chk($sformatf("m%0d_rvalid_rst", p), 32'(rv), 32'h0);
            chk($sformatf("m%0d_rdata_rst", p), rd, 32'h0);
            chk($sformatf("m%0d_err_rst", p), 32'(er), 32'h0);
            seen_rdata[p] = 32'h0;
            seen_err[p]   = 1'b0;
            if (p == 1) rq1.delete(); else rq0.delete();
        end else if (rv) begin
            if (qs == 0) begin
                chk($sformatf("m%0d_rvalid_spurious", p), 32'(rv), 32'h0);
            end else begin
                e = (p == 1) ? rq1.pop_front() : rq0.pop_front();
                chk($sformatf("m%0d_rdata", p), rd, e.rdata);
                chk($sformatf("m%0d_err", p), 32'(er), 32'(e.err));
                chk($sformatf("m%0d_latency", p), 32'(cyc), 32'(e.cyc + 1));
            end
            seen_rdata[p] = rd;
            seen_err[p]   = er;
        end else begin
            chk($sformatf("m%0d_rdata_hold", p), rd, seen_rdata[p]);
            chk($sformatf("m%0d_err_hold", p), 32'(er), 32'(seen_err[p]));
            chk($sformatf("m%0d_rvalid_missing", p), 32'(qs), 32'h0);
        end
    endtask

    // Response monitor, just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            check_resp(0);
            check_resp(1);
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input int p, input logic r, input logic w, input logic l,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            p0.req = r; p0.we = w; p0.lock = l; p0.addr = a; p0.wdata = d;
        end else begin
            p1.req = r; p1.we = w; p1.lock = l; p1.addr = a; p1.wdata = d;
        end
    endtask

    task automatic wait_gnt(input int p);
        int k;
        k = 0;
        forever begin
            @(negedge clk);
            if ((p == 1) ? p1.gnt : p0.gnt) break;
            k++;
            if (k >= 300) begin
                n_vec++;
                n_err++;
                $display("FAIL m%0d_gnt_timeout: no grant after %0d cycles", p, k);
                break;
            end
        end
    endtask

    task automatic requester(input int p, input int n);
        int          idle;
        logic [29:0] word;
        logic [31:0] a;
        logic        w, l;
        for (int i = 0; i < n; i++) begin
            idle = $urandom_range(0, 2);
            repeat (idle) begin
                drive(p, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
                @(posedge clk); #2;
            end
            word = 30'($urandom_range(0, 69));
            if ($urandom_range(0, 15) == 0) word = 30'h3FFF_FFF0;
            a = {word, 2'($urandom_range(0, 3))};
            w = 1'($urandom_range(0, 1));
            l = (p == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) == 0);
            drive(p, 1'b1, w, l, a, $urandom);
            wait_gnt(p);
            @(posedge clk); #2;
        end
        drive(p, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios, then random traffic ----------------
    initial begin
        int rr_exp [4];
        rr_exp = '{0, 1, 0, 1};
        for (int i = 0; i < DEPTH; i++) begin
            dmem_arr[i] = init_val(i);
            ref_mem[i]  = init_val(i);
        end
        seen_rdata[0] = 32'h0; seen_rdata[1] = 32'h0;
        seen_err[0]   = 1'b0;  seen_err[1]   = 1'b0;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Reset then idle.
        repeat (5) begin
            @(negedge clk);
            chk("idle_mem_we", 32'(mem_we), 32'h0);
            chk("idle_gnt", 32'({p0.gnt, p1.gnt}), 32'h0);
            @(posedge clk); #1;
            chk("idle_rvalid", 32'({p0.rvalid, p1.rvalid}), 32'h0);
            chk("idle_rdata", p0.rdata | p1.rdata, 32'h0);
            chk("idle_err", 32'({p0.err, p1.err}), 32'h0);
            #1;
        end

        // Port 0 write then read of 0x10.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_m0_gnt", 32'(p0.gnt), 32'h1);
        chk("wr_mem_we", 32'(mem_we), 32'h1);
        @(posedge clk); #1;
        chk("wr_rvalid", 32'(p0.rvalid), 32'h1);
        chk("wr_err", 32'(p0.err), 32'h0);
        #1;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("rd_m0_gnt", 32'(p0.gnt), 32'h1);
        @(posedge clk); #1;
        chk("rd_rvalid", 32'(p0.rvalid), 32'h1);
        chk("rd_rdata", p0.rdata, 32'hDEAD_BEEF);
        #1;

        // Lock burst by port 1 while port 0 waits (port 0 was served last).
        drive(0, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
        drive(1, 1'b1, 1'b1, 1'b1, 32'h0, 32'hA000_0000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lock_m0_gnt", 32'(p0.gnt), 32'h0);
            chk("lock_m1_gnt", 32'(p1.gnt), 32'h1);
            @(posedge clk); #2;
            if (k < 2) drive(1, 1'b1, 1'b1, (k + 1) < 2, 32'((k + 1) * 4), 32'hA000_0000 + 32'(k + 1));
            else       drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        end
        @(negedge clk);
        chk("after_lock_m0_gnt", 32'(p0.gnt), 32'h1);
        @(posedge clk); #2;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Contention after reset: round-robin alternates, fixed priority keeps port 0.
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_m0_gnt", 32'(p0.gnt), 32'(rr_exp[k] == 0));
            chk("rr_m1_gnt", 32'(p1.gnt), 32'(rr_exp[k] == 1));
            chk("fix_m0_gnt", 32'(f0.gnt), 32'h1);
            chk("fix_m1_gnt", 32'(f1.gnt), 32'h0);
            @(posedge clk); #1;
            chk("rr_m0_rvalid", 32'(p0.rvalid), 32'(rr_exp[k] == 0));
            #1;
        end
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #2;

        // Out-of-range write then read of word 64.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h1234_5678);
        @(negedge clk);
        chk("oor_wr_gnt", 32'(p0.gnt), 32'h1);
        chk("oor_mem_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        chk("oor_wr_rvalid", 32'(p0.rvalid), 32'h1);
        chk("oor_wr_err", 32'(p0.err), 32'h1);
        #1;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0);
        @(posedge clk); #1;
        chk("oor_rd_rvalid", 32'(p0.rvalid), 32'h1);
        chk("oor_rd_rdata", p0.rdata, 32'h0);
        chk("oor_rd_err", 32'(p0.err), 32'h1);
        #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("oor_word0_intact", dmem_arr[0], 32'hA000_0000);

        // Reset arriving while port 0 owns the bus and is granted a write.
        drive(0, 1'b1, 1'b1, 1'b1, 32'h24, 32'hCAFE_0024);
        @(posedge clk); #2;
        drive(0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h0BAD_F00D);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_m0_gnt", 32'(p0.gnt), 32'h1);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        chk("rst_no_rvalid", 32'(p0.rvalid), 32'h0);
        #1;
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        chk("post_rst_m1_gnt", 32'(p1.gnt), 32'h1);
        @(posedge clk); #1;
        chk("post_rst_rdata", p1.rdata, init_val(8));
        #1;
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #2;

        // Random traffic from both requesters.
        fork
            requester(0, 150);
            requester(1, 150);
        join
        repeat (4) begin
            @(posedge clk);
        end
        #2;
        chk("final_q0_empty", 32'(rq0.size()), 32'h0);
        chk("final_q1_empty", 32'(rq1.size()), 32'h0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("mem_word_%0d", i), dmem_arr[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory (dmem: clk, addr, we, wr_data, rd; synchronous write, combinational read) between two requesters.
  - Port 0 is the core data port.
  - Port 1 is the debug/program loader.
- Performs round-robin or fixed-priority arbitration, supports locked back-to-back ownership, registers read data with a 1-cycle response, and flags out-of-range addresses.
- Sits between the requesters and the dmem instance.

Parameters:
- WIDTH, 32: data and address width, equal to `Width.
- DEPTH_WORDS, 64: number of valid dmem words. A word address (addr[31:2]) >= DEPTH_WORDS is out of range.
- RR_EN, 1: 1 selects round-robin; 0 gives port 0 fixed priority.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- m0_req  in  1  port 0 access request.
- m0_we  in  1  port 0 write enable (0 = read).
- m0_lock  in  1  keep ownership after this access.
- m0_addr  in  WIDTH  byte address.
- m0_wdata  in  WIDTH  write data.
- m0_gnt  out  1  access accepted this cycle.
- m0_rvalid  out  1  read response valid.
- m0_rdata  out  WIDTH  read data.
- m0_err  out  1  out-of-range flag, qualified by m0_rvalid.
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as the port 0 signals, for port 1.
- mem_addr  out  WIDTH  to dmem addr.
- mem_we  out  1  to dmem we.
- mem_wr_data  out  WIDTH  to dmem wr_data.
- mem_rd  in  WIDTH  from dmem rd.

Behaviour:
- Reset: sampled on rising clk edge. All registered outputs go to 0:
  - m*_rvalid, m*_rdata, m*_err = 0.
  - FSM goes to ARB.
  - Round-robin pointer last = 1, so port 0 wins the first contention.
  - Reset mid-operation discards any pending response. A write granted in the reset cycle is suppressed, because mem_we is forced to 0 while reset is high.
- Request hold rule: a requester holds req, we, addr and wdata stable until it sees gnt. Exactly one access occurs per gnt cycle.
- Grant and datapath:
  - gnt is combinational in the same cycle.
  - At most one of m0_gnt/m1_gnt is high.
  - mem_addr and mem_wr_data are muxed from the granted port. With no grant, they come from port 0.
  - mem_we = gnt & we & in_range & ~reset.
  - An out-of-range write is dropped and does not reach memory.
- Arbitration in state ARB:
  - Single requester: it is granted.
  - Both requesting, RR_EN=1: the port other than last is granted.
  - Both requesting, RR_EN=0: port 0 is granted.
  - last updates to the granted port on each grant.
- FSM states: ARB, OWN0, OWN1.
  - ARB -> OWNn when port n is granted with mn_lock=1.
  - In OWNn, only port n can be granted. The other port's requests wait.
  - OWNn -> ARB on the first cycle where port n is granted with lock=0, or where mn_req=0. A dropped req releases ownership with no grant that cycle.
  - Lock held indefinitely starves the other port. This is by design; the loader only locks for bounded bursts.
- Read response:
  - On a granted read, mn_rdata <= mem_rd (or 0 if out of range) and mn_err <= out_of_range at the clock edge.
  - mn_rvalid is a 1-cycle pulse in the cycle after the grant.
  - Back-to-back reads give consecutive rvalid pulses.
- Write response: a granted write produces an mn_rvalid pulse with rdata = 0 and err = out_of_range, so every access gets exactly one response.
- Non-granted port: its rvalid stays 0. Its rdata and err hold their previous values.
- Address decode: in_range = (addr[31:2] < DEPTH_WORDS). Low two address bits pass through unchanged.

Decomposition:
- Shared package/header holds:
  - `Width (32).
  - FSM state encodings ST_ARB=2'd0, ST_OWN0=2'd1, ST_OWN1=2'd2.
  - The DEPTH_WORDS default.
- Natural sub-module: dmem_arb_resp. One instance per port, holding the rvalid/rdata/err registers, so the top contains only the FSM, the arbiter and the mux.

Test Plan:
- Reset then idle: after reset, all outputs = 0 and mem_we = 0 for 5 cycles with no req.
- Single port 0 write then read: m0 write addr 0x10, data 0xDEADBEEF.
  - m0_gnt = 1 and mem_we = 1 in the same cycle, then rvalid pulse with err = 0.
  - A read of 0x10 returns m0_rdata = 0xDEADBEEF with m0_rvalid one cycle after gnt.
- Contention, RR_EN=1: both ports request reads continuously. Grants alternate 0,1,0,1 for 4 cycles, each rvalid lagging its gnt by 1. With RR_EN=0, port 0 is granted 4 of 4.
- Lock burst: m1 locks and issues 3 writes to 0x0, 0x4, 0x8 while m0 requests.
  - m0_gnt stays 0 for those 3 cycles.
  - m1 lock=0 on the 3rd write returns the FSM to ARB.
  - m0 is granted on the next cycle.
- Out of range: m0 writes 0x100 (word 64) with data 0x12345678.
  - mem_we = 0, m0_rvalid = 1, m0_err = 1.
  - A subsequent read of 0x100 returns rdata = 0, err = 1. Memory contents are unchanged.
- Reset mid-operation: assert reset in the cycle m0 is granted a write to 0x20. No memory write occurs, no rvalid follows, and the FSM is in ARB after reset.
